// File: rtl/latch_pipe_rst_if.sv
// rtl/latch_pipe_rst_if.sv - handshake/bus interface for the latch_pipe_rst pipeline
//
// Signals:
//   in_data   WIDTH            write data
//   in_valid  1                write request
//   in_ready  1                stage 0 can accept this cycle
//   out_data  WIDTH            data of the last stage
//   out_valid 1                last stage holds valid data
//   out_ready 1                consumer accepts out_data
//   occupancy $clog2(DEPTH+1)  count of valid stages
//   par_err   1                parity error on output (only with LATCH_PIPE_PARITY_EN)
// Modports: master (producer/consumer side), slave (pipeline side).
interface latch_pipe_rst_if #(
    parameter int WIDTH = 8,
    parameter int DEPTH = 4
);
    localparam int OW = $clog2(DEPTH + 1);

    logic [WIDTH-1:0] in_data;
    logic             in_valid;
    logic             in_ready;
    logic [WIDTH-1:0] out_data;
    logic             out_valid;
    logic             out_ready;
    logic [OW-1:0]    occupancy;
`ifdef LATCH_PIPE_PARITY_EN
    logic             par_err;
`endif

    modport master (
        output in_data, in_valid, out_ready,
        input  in_ready, out_data, out_valid, occupancy
`ifdef LATCH_PIPE_PARITY_EN
        , input par_err
`endif
    );

    modport slave (
        input  in_data, in_valid, out_ready,
        output in_ready, out_data, out_valid, occupancy
`ifdef LATCH_PIPE_PARITY_EN
        , output par_err
`endif
    );
endinterface

// File: rtl/latch_pipe_rst.sv
// rtl/latch_pipe_rst.sv - stallable latch-pair pipeline with valid/ready handshake
//
// Ports:
//   CLK   input   clock; each stage captures at the falling edge
//   RSTB  input   asynchronous active-low reset
//   bus   slave   latch_pipe_rst_if (in_data/in_valid/in_ready,
//                 out_data/out_valid/out_ready, occupancy[, par_err])
// Parameters: WIDTH (1..64), DEPTH (1..16), RST_VAL (truncated to WIDTH).
// Optional feature macro: LATCH_PIPE_PARITY_EN adds a carried even-parity
// bit per stage and the par_err output.
module latch_pipe_rst #(
    parameter int          WIDTH   = 8,
    parameter int          DEPTH   = 4,
    parameter logic [63:0] RST_VAL = 64'd0
) (
    input  logic              CLK,
    input  logic              RSTB,
    latch_pipe_rst_if.slave   bus
);
    localparam int OW = $clog2(DEPTH + 1);
`ifdef LATCH_PIPE_PARITY_EN
    localparam int E  = WIDTH + 1;
`else
    localparam int E  = WIDTH;
`endif
    localparam logic [WIDTH-1:0] RST_D = RST_VAL[WIDTH-1:0];
    // Parity bit (when present) resets to 0 regardless of RST_VAL.
    localparam logic [E-1:0]     RST_E = E'(RST_D);

    logic [DEPTH-1:0][E-1:0] w_sd;
    logic [DEPTH-1:0]        w_sv;
    logic [DEPTH-1:0]        w_adv;
    logic [E-1:0]            w_in_d;
    logic [OW-1:0]           w_occ;

`ifdef LATCH_PIPE_PARITY_EN
    assign w_in_d = {^bus.in_data, bus.in_data};
`else
    assign w_in_d = bus.in_data;
`endif

    // Advance chain: an empty stage always advances, so bubbles collapse and
    // back-pressure only reaches in_ready when everything downstream is full.
    always_comb begin
        w_adv = '0;
        w_adv[DEPTH-1] = !w_sv[DEPTH-1] | bus.out_ready;
        for (int i = DEPTH - 2; i >= 0; i--) begin
            w_adv[i] = !w_sv[i] | w_adv[i+1];
        end
    end

    for (genvar i = 0; i < DEPTH; i++) begin : g_stage
        logic [E-1:0] r_m;
        logic [E-1:0] r_s;
        logic         r_mv;
        logic         r_sv;
        logic         r_en;
        logic [E-1:0] w_up_d;
        logic         w_up_v;

        if (i == 0) begin : g_head
            assign w_up_d = w_in_d;
            assign w_up_v = bus.in_valid;
        end else begin : g_body
            assign w_up_d = w_sd[i-1];
            assign w_up_v = w_sv[i-1];
        end

        // Enable latch, transparent while CLK is high: freezes the advance
        // decision at the falling edge so the low-phase latch opens only if
        // the high-phase latch was open at the edge. Held at 0 in reset so a
        // falling edge coincident with RSTB rising captures nothing.
        always_latch begin
            if (!RSTB) begin
                r_en <= 1'b0;
            end else if (CLK) begin
                r_en <= w_adv[i];
            end
        end

        // High-transparent latch: tracks upstream while this stage advances.
        always_latch begin
            if (!RSTB) begin
                r_m  <= RST_E;
                r_mv <= 1'b0;
            end else if (CLK && r_en) begin
                r_m  <= w_up_d;
                r_mv <= w_up_v;
            end
        end

        // Low-transparent latch: output is stable across the CLK-high phase.
        always_latch begin
            if (!RSTB) begin
                r_s  <= RST_E;
                r_sv <= 1'b0;
            end else if (!CLK && r_en) begin
                r_s  <= r_m;
                r_sv <= r_mv;
            end
        end

        assign w_sd[i] = r_s;
        assign w_sv[i] = r_sv;
    end

    // Occupancy is the count of valid stages; it moves only when the valid
    // bits move at a falling edge and is bounded to 0..DEPTH by construction.
    always_comb begin
        w_occ = '0;
        for (int i = 0; i < DEPTH; i++) begin
            w_occ = w_occ + OW'(w_sv[i]);
        end
    end

    assign bus.in_ready  = w_adv[0];
    assign bus.out_data  = w_sd[DEPTH-1][WIDTH-1:0];
    assign bus.out_valid = w_sv[DEPTH-1];
    assign bus.occupancy = w_occ;

`ifdef LATCH_PIPE_PARITY_EN
    // Odd parity over data plus carried bit means corruption in flight.
    assign bus.par_err = w_sv[DEPTH-1] & (^w_sd[DEPTH-1]);
`endif
endmodule

// File: tb/tb_latch_pipe_rst.sv
// tb/tb_latch_pipe_rst.sv - directed self-checking bench for latch_pipe_rst
module tb_latch_pipe_rst;
    logic CLK;
    logic RSTB;
    int   errors = 0;
    int   checks = 0;

    latch_pipe_rst_if #(.WIDTH(8), .DEPTH(4)) bus ();

    latch_pipe_rst #(.WIDTH(8), .DEPTH(4), .RST_VAL(64'h0)) dut (
        .CLK  (CLK),
        .RSTB (RSTB),
        .bus  (bus)
    );

    initial CLK = 1'b1;
    always #5 CLK = ~CLK;

    task automatic tick;
        @(negedge CLK);
        #1;
    endtask

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp)
        else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    initial begin
        RSTB          = 1'b0;
        bus.in_valid  = 1'b0;
        bus.in_data   = 8'h00;
        bus.out_ready = 1'b0;

        // 1. Reset with random inputs, then release on a falling edge.
        repeat (3) begin
            bus.in_valid  = 1'($urandom);
            bus.in_data   = 8'($urandom);
            bus.out_ready = 1'($urandom);
            tick();
        end
        check("rst_out_valid", 64'(bus.out_valid), 64'd0);
        check("rst_occupancy", 64'(bus.occupancy), 64'd0);
        check("rst_in_ready",  64'(bus.in_ready),  64'd1);
        check("rst_out_data",  64'(bus.out_data),  64'h00);
`ifdef LATCH_PIPE_PARITY_EN
        check("rst_par_err",   64'(bus.par_err),   64'd0);
`endif
        bus.in_valid  = 1'b1;
        bus.in_data   = 8'h99;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        RSTB = 1'b1;
        #1;
        check("rel_no_capture", 64'(bus.occupancy), 64'd0);
        tick();
        check("rel_first_capture", 64'(bus.occupancy), 64'd1);
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        check("rel_out_data",  64'(bus.out_data),  64'h99);
        check("rel_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        check("rel_drained", 64'(bus.occupancy), 64'd0);

        // 2. Streaming with out_ready held high.
        bus.in_valid = 1'b1;
        bus.in_data = 8'h11; tick();
        bus.in_data = 8'h22; tick();
        bus.in_data = 8'h33; tick();
        check("stream_occ_peak", 64'(bus.occupancy), 64'd3);
        bus.in_valid = 1'b0;
        tick();
        check("stream_w0", 64'(bus.out_data), 64'h11);
        check("stream_v0", 64'(bus.out_valid), 64'd1);
        tick();
        check("stream_w1", 64'(bus.out_data), 64'h22);
        tick();
        check("stream_w2", 64'(bus.out_data), 64'h33);
        tick();
        check("stream_empty_v", 64'(bus.out_valid), 64'd0);
        check("stream_empty_occ", 64'(bus.occupancy), 64'd0);

        // 3. Fill under back-pressure, then simultaneous push/pop when full.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'hA1; tick();
        bus.in_data = 8'hA2; tick();
        bus.in_data = 8'hA3; tick();
        check("fill_ready_3", 64'(bus.in_ready), 64'd1);
        bus.in_data = 8'hA4; tick();
        check("fill_occ",      64'(bus.occupancy), 64'd4);
        check("fill_in_ready", 64'(bus.in_ready),  64'd0);
        check("fill_head",     64'(bus.out_data),  64'hA1);
        bus.in_data = 8'hA5; tick();
        check("fill_hold_occ",  64'(bus.occupancy), 64'd4);
        check("fill_hold_head", 64'(bus.out_data),  64'hA1);
        @(posedge CLK);
        #2;
        check("fill_high_stable", 64'(bus.out_data), 64'hA1);
        bus.out_ready = 1'b1;
        #1;
        check("full_pop_ready", 64'(bus.in_ready), 64'd1);
        tick();
        check("full_pushpop_occ",  64'(bus.occupancy), 64'd4);
        check("full_pushpop_head", 64'(bus.out_data),  64'hA2);
        bus.in_valid = 1'b0;
        tick(); tick(); tick();
        check("fill_last_word", 64'(bus.out_data),  64'hA5);
        check("fill_last_occ",  64'(bus.occupancy), 64'd1);
        tick();
        check("fill_drained", 64'(bus.occupancy), 64'd0);

        // 4. Bubble collapse.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1; bus.in_data = 8'hA5; tick();
        bus.in_valid  = 1'b0; tick(); tick();
        bus.in_valid  = 1'b1; bus.in_data = 8'h5A; tick();
        bus.in_valid  = 1'b0; tick(); tick(); tick();
        check("bubble_occ",      64'(bus.occupancy), 64'd2);
        check("bubble_in_ready", 64'(bus.in_ready),  64'd1);
        check("bubble_head",     64'(bus.out_data),  64'hA5);
        bus.out_ready = 1'b1;
        tick();
        check("bubble_second", 64'(bus.out_data),  64'h5A);
        check("bubble_occ1",   64'(bus.occupancy), 64'd1);
        tick();
        check("bubble_drained", 64'(bus.occupancy), 64'd0);

        // 5. Reset in the middle of operation, between edges.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'h01; tick();
        bus.in_data = 8'h02; tick();
        bus.in_data = 8'h03; tick();
        bus.in_valid = 1'b0;
        check("mid_pre_occ", 64'(bus.occupancy), 64'd3);
        #2;
        RSTB = 1'b0;
        #1;
        check("mid_rst_occ",      64'(bus.occupancy), 64'd0);
        check("mid_rst_valid",    64'(bus.out_valid), 64'd0);
        check("mid_rst_in_ready", 64'(bus.in_ready),  64'd1);
        check("mid_rst_data",     64'(bus.out_data),  64'h00);
        bus.in_data   = 8'h7E;
        bus.in_valid  = 1'b1;
        bus.out_ready = 1'b1;
        @(negedge CLK);
        RSTB = 1'b1;
        #1;
        check("mid_rel_no_capture", 64'(bus.occupancy), 64'd0);
        tick();
        check("mid_capture", 64'(bus.occupancy), 64'd1);
        bus.in_valid = 1'b0;
        tick(); tick();
        check("mid_not_yet", 64'(bus.out_valid), 64'd0);
        tick();
        check("mid_out_data",  64'(bus.out_data),  64'h7E);
        check("mid_out_valid", 64'(bus.out_valid), 64'd1);
        tick();
        check("mid_drained", 64'(bus.occupancy), 64'd0);

`ifdef LATCH_PIPE_PARITY_EN
        // 6. Corrupt one word while it sits in stage 2.
        bus.out_ready = 1'b0;
        bus.in_valid  = 1'b1;
        bus.in_data = 8'h01; tick();
        bus.in_data = 8'h02; tick();
        bus.in_data = 8'h04; tick();
        bus.in_valid = 1'b0;
        force dut.g_stage[2].r_s = 9'h103;
        release dut.g_stage[2].r_s;
        bus.out_ready = 1'b1;
        tick();
        check("par_bad_data", 64'(bus.out_data), 64'h03);
        check("par_bad_err",  64'(bus.par_err),  64'd1);
        tick();
        check("par_next_data", 64'(bus.out_data), 64'h02);
        check("par_next_err",  64'(bus.par_err),  64'd0);
        tick();
        check("par_last_err", 64'(bus.par_err), 64'd0);
        tick();
`endif

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
